axi_burst_ram: RTL and testbench
================================

// Module: axi_burst_ram
// PURPOSE
//  AXI4 slave memory directly downstream of external_req_arbitrer; consumes its single m_axi port.
//  Serves the cache line bursts issued by I$ refills and D$ refill/write-back (INCR, 32-bit beats).
//  Acts as the simulation and FPGA backing store for Holy Core V2.
//  Executes one transaction at a time, matching the arbitrer's one-owner-at-a-time muxing.
// PARAMETERS
//  MEM_WORDS   4096        depth in 32-bit words (power of two)
//  BASE_ADDR   32'h0       byte address of word 0
//  ID_WIDTH    4           AXI ID width, matching axi_if
// PORTS
//  clk     in   1        clock
//  rst     in   1        synchronous, active-high reset
//  s_axi   slave axi_if  AXI4 slave modport
//          uses AW/W/B/AR/R channels; ignores awsize/arsize/awburst/arburst (always 32-bit INCR)
// BEHAVIOUR
//  Reset values:
//   - bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0.
//   - While rst=1: awready=0, wready=0, arready=0.
//   - Memory contents are not cleared.
//  FSM states: IDLE, W_DATA, W_RESP, R_DATA.
//  IDLE:
//   - awready=1.
//   - arready = !awvalid (write wins when AW and AR are valid in the same cycle).
//   - AW handshake: capture awaddr, awlen, awid; beat counter <= 0; go to W_DATA.
//   - AR handshake: capture araddr, arlen, arid; go to R_DATA.
//   - In the AR handshake cycle, load rdata <= mem[idx(araddr)]; rvalid=1 on the next cycle (1-cycle latency).
//  W_DATA:
//   - wready=1.
//   - Per W handshake: write lanes selected by wstrb into mem[idx(addr)]; addr += 4; beat++.
//   - Leave on the beat with wlast=1, or on beat==awlen, whichever comes first.
//   - If wlast=1 before beat==awlen, or beat==awlen without wlast: set the sticky error flag.
//   - Go to W_RESP.
//  W_RESP:
//   - bvalid=1 from the cycle after the final W beat; bid = captured awid.
//   - bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00.
//   - Hold until bready; then go to IDLE and clear the flag.
//  R_DATA:
//   - rvalid=1; rid = captured arid; rlast = (beat==arlen).
//   - On rvalid&&rready with !rlast: addr += 4; beat++; rdata <= mem[next idx] in the same edge.
//     This gives full throughput of 1 beat/cycle under continuous rready.
//   - rready=0: rdata, rlast, rresp are held stable.
//   - On rvalid&&rready&&rlast: rvalid <= 0; go to IDLE.
//  Indexing:
//   - idx(a) = ((a - BASE_ADDR) >> 2) mod MEM_WORDS.
//   - Counters are 8 bits (awlen/arlen up to 255).
//   - The address counter is 32 bits and wraps silently at 2^32.
//  Reset mid-burst:
//   - State goes to IDLE and outputs return to reset values on the next edge.
//   - The partial burst is abandoned; beats already written remain in memory.
//  No outstanding transactions and no reordering. AW is not accepted during a read, nor AR during a write.
// CONFIGURATION
//  Macro AXI_RAM_RANGE_CHECK_EN:
//   - Defined: a beat whose address lies outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) is a write no-op.
//     Such a read beat returns rdata=0 with rresp=SLVERR.
//     Any out-of-range write beat sets the error flag, so bresp=SLVERR.
//     In-range beats of the same burst complete normally.
//   - Undefined: indices wrap modulo MEM_WORDS; responses are always OKAY except the wlast mismatch case.
// TESTING
//  1) AW addr=0x100, len=127; 128 W beats data=i, wstrb=F -> bresp=OKAY, bid=awid.
//     Then AR same addr/len -> 128 beats data=i, rlast only on beat 127, no gaps under rready=1.
//  2) Read burst with rready toggling 1/0 each cycle -> same data sequence; rdata stable while stalled.
//     Duration 2x beats.
//  3) AWVALID and ARVALID asserted in the same cycle -> write accepted first.
//     arready=0 until B completes; then the read returns the newly written data.
//  4) Write 0xAABBCCDD then write 0x11223344 with wstrb=4'b0101 -> read returns 0xAA22CC44.
//  5) rst=1 for 1 cycle at beat 40 of a 128-beat write -> wready/bvalid=0 next cycle.
//     A new AW is accepted; words 0..39 hold the new data; word 40 is unchanged.
//  6) With AXI_RAM_RANGE_CHECK_EN, burst len=3 starting 8 bytes below the top of memory:
//     - read -> beats 0-1 OKAY with data, beats 2-3 SLVERR with 0;
//     - write -> bresp=SLVERR, word 0 unchanged.
//     Without the macro: the same burst wraps to words 0-1, all OKAY.

Source files
------------

// File: rtl/axi_burst_ram_if.sv
// AXI4 bundle shared by the arbitrer's master port and the backing-store slave.
// Burst type and size are not carried; every burst here is 32-bit INCR.
interface axi_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_burst_ram.sv
// Single-transaction AXI4 burst RAM backing store (32-bit INCR beats, write wins over read).
// Optional macro AXI_RAM_RANGE_CHECK_EN: out-of-range beats are dropped and answered with SLVERR.
module axi_burst_ram #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          ID_WIDTH  = 4
) (
  input  logic clk,
  input  logic rst,
  axi_if.slave s_axi
);
  localparam int IW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, W_DATA, W_RESP, R_DATA} state_t;

  typedef struct packed {
    logic [31:0]         addr;
    logic [7:0]          len;
    logic [ID_WIDTH-1:0] id;
  } burst_t;

  state_t      state, state_nxt;
  burst_t      cur;
  logic [7:0]  beat;
  logic        err;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] mem [MEM_WORDS];

  logic        awready, arready, wready, rlast;
  logic        aw_hs, ar_hs, wr_hs, b_hs, r_hs;
  logic        wr_ok, wr_bad, rd_load;
  logic [31:0] rd_addr, rd_word;
  logic [1:0]  rd_resp;

  function automatic logic [IW-1:0] idx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction

`ifdef AXI_RAM_RANGE_CHECK_EN
  function automatic logic in_range(input logic [31:0] a);
    return ((a - BASE_ADDR) >> (IW + 2)) == 32'd0;
  endfunction
`endif

  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    case (state)
      IDLE: begin
        awready = 1'b1;
        arready = !s_axi.awvalid;
        if (s_axi.awvalid)      state_nxt = W_DATA;
        else if (s_axi.arvalid) state_nxt = R_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (s_axi.wvalid && (s_axi.wlast || beat == cur.len)) state_nxt = W_RESP;
      end
      W_RESP: if (s_axi.bready) state_nxt = IDLE;
      R_DATA: if (rvalid_q && s_axi.rready && rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      awready   = 1'b0;
      arready   = 1'b0;
      wready    = 1'b0;
      state_nxt = IDLE;
    end
  end

  assign rlast   = rvalid_q && (beat == cur.len);
  assign aw_hs   = s_axi.awvalid && awready;
  assign ar_hs   = s_axi.arvalid && arready;
  assign wr_hs   = s_axi.wvalid && wready;
  assign b_hs    = (state == W_RESP) && s_axi.bready && !rst;
  assign r_hs    = rvalid_q && s_axi.rready;
  assign rd_load = ar_hs || (r_hs && !rlast);
  // AR loads the first word; each accepted non-last beat prefetches the next one
  assign rd_addr = (state == IDLE) ? s_axi.araddr : cur.addr + 32'd4;
  assign rd_word = mem[idx(rd_addr)];

`ifdef AXI_RAM_RANGE_CHECK_EN
  assign wr_ok   = wr_hs && in_range(cur.addr);
  assign wr_bad  = wr_hs && !in_range(cur.addr);
  assign rd_resp = in_range(rd_addr) ? 2'b00 : 2'b10;
`else
  assign wr_ok   = wr_hs;
  assign wr_bad  = 1'b0;
  assign rd_resp = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < 4; b++)
        if (s_axi.wstrb[b]) mem[idx(cur.addr)][8*b +: 8] <= s_axi.wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= '0;
      beat     <= 8'd0;
      err      <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rresp_q  <= 2'b00;
    end else begin
      state <= state_nxt;
      if (aw_hs) begin
        cur  <= '{addr: s_axi.awaddr, len: s_axi.awlen, id: s_axi.awid};
        beat <= 8'd0;
      end else if (ar_hs) begin
        cur      <= '{addr: s_axi.araddr, len: s_axi.arlen, id: s_axi.arid};
        beat     <= 8'd0;
        rvalid_q <= 1'b1;
      end
      if (wr_hs) begin
        cur.addr <= cur.addr + 32'd4;
        beat     <= beat + 8'd1;
        // early wlast or missing wlast both poison the response
        if (s_axi.wlast != (beat == cur.len) || wr_bad) err <= 1'b1;
      end
      if (b_hs) err <= 1'b0;
      if (r_hs) begin
        if (rlast) rvalid_q <= 1'b0;
        else begin
          cur.addr <= cur.addr + 32'd4;
          beat     <= beat + 8'd1;
        end
      end
      if (rd_load) begin
        rdata_q <= (rd_resp == 2'b00) ? rd_word : 32'd0;
        rresp_q <= rd_resp;
      end
    end
  end

  assign s_axi.awready = awready;
  assign s_axi.arready = arready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = (state == W_RESP);
  assign s_axi.bresp   = {err, 1'b0};
  assign s_axi.bid     = cur.id;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast;
  assign s_axi.rid     = cur.id;
endmodule

// File: tb/tb_axi_burst_ram.sv
// Directed bench for axi_burst_ram: bursts, stalls, AW/AR priority, byte strobes,
// mid-burst reset, wlast mismatch and top-of-memory wrap / range check.
module tb_axi_burst_ram;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_if #(.ID_WIDTH(4)) bus ();

  axi_burst_ram #(.MEM_WORDS(4096), .BASE_ADDR(32'h0), .ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .s_axi(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] rd_data [256];
  logic        rd_last [256];
  logic [1:0]  rd_resp [256];
  int          rd_n, rd_cyc, rd_gaps, rd_stall_bad, rd_id_bad;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic aw(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    bus.awaddr = a; bus.awlen = len; bus.awid = id; bus.awvalid = 1'b1;
    while (!bus.awready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("aw_timeout", bus.awready, 1);
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic wbeats(input int n, input logic [31:0] base, input logic [3:0] strb, input int last_at);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      bus.wvalid = 1'b1; bus.wdata = base + i; bus.wstrb = strb; bus.wlast = (i == last_at);
      while (!bus.wready && k < 50) begin tick(); k++; end
      if (k >= 50) chk("w_timeout", bus.wready, 1);
      tick();
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic bget();
    int k = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && k < 50) begin tick(); k++; end
    if (k >= 50) chk("b_timeout", bus.bvalid, 1);
    b_resp = bus.bresp; b_id = bus.bid;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id, input bit toggle);
    int n = 0;
    logic [31:0] held;
    logic held_last;
    bit held_v = 0;
    held = '0; held_last = 1'b0;
    bus.araddr = a; bus.arlen = len; bus.arid = id; bus.arvalid = 1'b1;
    while (!bus.arready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("ar_timeout", bus.arready, 1);
    tick();
    bus.arvalid = 1'b0;
    rd_n = 0; rd_cyc = 0; rd_gaps = 0; rd_stall_bad = 0; rd_id_bad = 0;
    while (rd_n <= int'(len) && rd_cyc < 2000) begin
      bus.rready = toggle ? rd_cyc[0] : 1'b1;
      if (!bus.rvalid) rd_gaps++;
      else begin
        if (held_v && (bus.rdata !== held || bus.rlast !== held_last)) rd_stall_bad++;
        if (bus.rid !== id) rd_id_bad++;
        if (bus.rready) begin
          rd_data[rd_n] = bus.rdata; rd_last[rd_n] = bus.rlast; rd_resp[rd_n] = bus.rresp;
          rd_n++; held_v = 0;
        end else begin
          held = bus.rdata; held_last = bus.rlast; held_v = 1;
        end
      end
      tick(); rd_cyc++;
    end
    bus.rready = 1'b0;
  endtask

  initial begin
    int bad, lbad;
    rst = 1'b1;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    tick(); tick(); tick();

    // reset state
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rlast", bus.rlast, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_bid", bus.bid, 0);
    chk("rst_rid", bus.rid, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 1'b0; #1;
    chk("idle_awready", bus.awready, 1);
    chk("idle_arready", bus.arready, 1);

    // 1) 128-beat write then full-rate read
    aw(32'h100, 8'd127, 4'd3);
    wbeats(128, 32'd0, 4'hF, 127);
    bget();
    chk("t1_bresp", b_resp, 0);
    chk("t1_bid", b_id, 3);
    rd_burst(32'h100, 8'd127, 4'd10, 1'b0);
    bad = 0; lbad = 0;
    for (int i = 0; i < 128; i++) begin
      if (rd_data[i] !== 32'(i)) bad++;
      if (rd_last[i] !== (i == 127)) lbad++;
    end
    chk("t1_beats", rd_n, 128);
    chk("t1_cycles", rd_cyc, 128);
    chk("t1_gaps", rd_gaps, 0);
    chk("t1_data_bad", bad, 0);
    chk("t1_rlast_bad", lbad, 0);
    chk("t1_rid_bad", rd_id_bad, 0);
    chk("t1_rvalid_after", bus.rvalid, 0);

    // 2) stalled read, rready alternating
    rd_burst(32'h100, 8'd15, 4'd11, 1'b1);
    bad = 0;
    for (int i = 0; i < 16; i++) if (rd_data[i] !== 32'(i) || rd_last[i] !== (i == 15)) bad++;
    chk("t2_beats", rd_n, 16);
    chk("t2_cycles", rd_cyc, 32);
    chk("t2_data_bad", bad, 0);
    chk("t2_stall_bad", rd_stall_bad, 0);

    // 3) AW and AR together: write first, AR blocked until B done
    bus.awaddr = 32'h3000; bus.awlen = 8'd0; bus.awid = 4'd5; bus.awvalid = 1'b1;
    bus.araddr = 32'h3000; bus.arlen = 8'd0; bus.arid = 4'd6; bus.arvalid = 1'b1;
    #1;
    chk("t3_arready_tie", bus.arready, 0);
    chk("t3_awready_tie", bus.awready, 1);
    tick();
    bus.awvalid = 1'b0;
    bad = 0;
    bus.wvalid = 1'b1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wlast = 1'b1;
    if (bus.arready) bad++;
    chk("t3_wready", bus.wready, 1);
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    if (bus.arready) bad++;
    chk("t3_bvalid", bus.bvalid, 1);
    chk("t3_bid", bus.bid, 5);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("t3_ar_blocked", bad, 0);
    chk("t3_arready_after_b", bus.arready, 1);
    tick();
    bus.arvalid = 1'b0;
    chk("t3_rvalid", bus.rvalid, 1);
    chk("t3_rdata", bus.rdata, 32'hCAFEF00D);
    chk("t3_rid", bus.rid, 6);
    chk("t3_rlast", bus.rlast, 1);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("t3_rvalid_done", bus.rvalid, 0);

    // 4) byte strobes
    aw(32'h3800, 8'd0, 4'd8); wbeats(1, 32'hAABBCCDD, 4'hF, 0); bget();
    aw(32'h3800, 8'd0, 4'd8); wbeats(1, 32'h11223344, 4'b0101, 0); bget();
    rd_burst(32'h3800, 8'd0, 4'd9, 1'b0);
    chk("t4_merge", rd_data[0], 32'hAA22CC44);

    // 5) reset at beat 40 of a 128-beat write
    aw(32'h10A0, 8'd0, 4'd1); wbeats(1, 32'hDEADBEEF, 4'hF, 0); bget();
    aw(32'h1000, 8'd127, 4'd2);
    wbeats(40, 32'h5000, 4'hF, -1);
    bus.wvalid = 1'b1; bus.wdata = 32'h5028; bus.wstrb = 4'hF; rst = 1'b1;
    tick();
    chk("t5_wready_rst", bus.wready, 0);
    chk("t5_bvalid_rst", bus.bvalid, 0);
    chk("t5_awready_rst", bus.awready, 0);
    rst = 1'b0; bus.wvalid = 1'b0; #1;
    chk("t5_wready_after", bus.wready, 0);
    chk("t5_awready_after", bus.awready, 1);
    aw(32'h2000, 8'd0, 4'd3); wbeats(1, 32'h77, 4'hF, 0); bget();
    chk("t5_new_bresp", b_resp, 0);
    rd_burst(32'h1000, 8'd40, 4'd4, 1'b0);
    bad = 0;
    for (int i = 0; i < 40; i++) if (rd_data[i] !== 32'h5000 + 32'(i)) bad++;
    chk("t5_words_bad", bad, 0);
    chk("t5_word40", rd_data[40], 32'hDEADBEEF);

    // 7) wlast mismatch: early wlast, missing wlast, then flag cleared
    aw(32'h2100, 8'd2, 4'd5); wbeats(2, 32'h900, 4'hF, 1); bget();
    chk("t7_early_wlast", b_resp, 2'b10);
    aw(32'h2100, 8'd1, 4'd6); wbeats(2, 32'h900, 4'hF, -1); bget();
    chk("t7_no_wlast", b_resp, 2'b10);
    aw(32'h2100, 8'd0, 4'd7); wbeats(1, 32'h900, 4'hF, 0); bget();
    chk("t7_cleared", b_resp, 2'b00);

    // 6) burst crossing the top of memory
    aw(32'h0, 8'd0, 4'd1); wbeats(1, 32'h0BAD0000, 4'hF, 0); bget();
    aw(32'h3FF8, 8'd3, 4'd7); wbeats(4, 32'h6000, 4'hF, 3); bget();
    rd_burst(32'h3FF8, 8'd3, 4'd7, 1'b0);
    chk("t6_beats", rd_n, 4);
    chk("t6_d0", rd_data[0], 32'h6000);
    chk("t6_d1", rd_data[1], 32'h6001);
    chk("t6_r0", rd_resp[0], 0);
    chk("t6_r1", rd_resp[1], 0);
`ifdef AXI_RAM_RANGE_CHECK_EN
    chk("t6_bresp", b_resp, 2'b10);
    chk("t6_d2", rd_data[2], 32'h0);
    chk("t6_d3", rd_data[3], 32'h0);
    chk("t6_r2", rd_resp[2], 2'b10);
    chk("t6_r3", rd_resp[3], 2'b10);
    rd_burst(32'h0, 8'd0, 4'd7, 1'b0);
    chk("t6_word0", rd_data[0], 32'h0BAD0000);
`else
    chk("t6_bresp", b_resp, 2'b00);
    chk("t6_d2", rd_data[2], 32'h6002);
    chk("t6_d3", rd_data[3], 32'h6003);
    chk("t6_r2", rd_resp[2], 2'b00);
    chk("t6_r3", rd_resp[3], 2'b00);
    rd_burst(32'h0, 8'd0, 4'd7, 1'b0);
    chk("t6_word0", rd_data[0], 32'h6002);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
